bus_bridge_bidir: RTL

BUS_BRIDGE_BIDIR -- requirements
Module: bus_bridge_bidir

---
 rtl/bus_bridge_bidir.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bus_bridge_bidir.sv
// Bidirectional bus bridge: forwards whichever side requests first to the other side,
// with registered outputs, a fixed turnaround gap and a saturating transfer counter.
module bus_bridge_bidir #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = {WIDTH{1'b1}},
    parameter int unsigned      TURN_CYC = 1,
    parameter bit               PRIO_A   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] a_out,
    output logic             a_oe,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] b_out,
    output logic             b_oe,
    output logic [1:0]       dir,
    output logic             contention,
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned CntW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StA2B  = 2'b01,
        StB2A  = 2'b10,
        StTurn = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_out_q, a_out_d, b_out_q, b_out_d;
    logic              a_oe_q, a_oe_d, b_oe_q, b_oe_d;
    logic              contention_q, contention_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic [CntW-1:0]   turn_cnt_q, turn_cnt_d;

    logic a_req, b_req;
    assign a_req = (a_in != IDLE_VAL);
    assign b_req = (b_in != IDLE_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (a_req && (!b_req || PRIO_A)) begin
                    state_d = StA2B;
                end else if (b_req) begin
                    state_d = StB2A;
                end
            end
            StA2B:   if (!a_req) state_d = StTurn;
            StB2A:   if (!b_req) state_d = StTurn;
            StTurn:  if (turn_cnt_q <= CntW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Keyed on state_d so the first forwarded word leaves on the same edge that enters A2B/B2A.
    always_comb begin
        a_out_d      = a_out_q;
        b_out_d      = b_out_q;
        a_oe_d       = 1'b0;
        b_oe_d       = 1'b0;
        contention_d = (state_q == StIdle) && a_req && b_req;
        xfer_cnt_d   = xfer_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        unique case (state_d)
            StA2B: begin
                b_oe_d  = 1'b1;
                b_out_d = a_in;
            end
            StB2A: begin
                a_oe_d  = 1'b1;
                a_out_d = b_in;
            end
            default: ;
        endcase
        if ((state_q == StA2B || state_q == StB2A) && state_d == StTurn) begin
            turn_cnt_d = CntW'(TURN_CYC);
            if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
        end else if (state_q == StTurn && turn_cnt_q != '0) begin
            turn_cnt_d = turn_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q      <= IDLE_VAL;
            b_out_q      <= IDLE_VAL;
            a_oe_q       <= 1'b0;
            b_oe_q       <= 1'b0;
            contention_q <= 1'b0;
            xfer_cnt_q   <= 16'h0000;
            turn_cnt_q   <= '0;
        end else begin
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            a_oe_q       <= a_oe_d;
            b_oe_q       <= b_oe_d;
            contention_q <= contention_d;
            xfer_cnt_q   <= xfer_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign a_oe       = a_oe_q;
    assign b_oe       = b_oe_q;
    assign dir        = state_q;
    assign contention = contention_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule
